// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter
// -----------------------------------------------------------------------------
// Purpose:
//   Round-robin arbiter that shares one resource among NUM_REQ requesters.
//   A wrap-around priority pointer (always < NUM_REQ) sets the scan start.
//   An owner is released by its done pulse, by dropping its request, or, when
//   MAX_HOLD != 0, after MAX_HOLD consecutive cycles. The latter is a forced
//   rotation and is flagged by a one-cycle preempt pulse. Re-arbitration
//   happens in the releasing cycle, so back-to-back grants have no bubble.
//
// Parameters:
//   NUM_REQ   number of requesters (2..16)
//   MAX_HOLD  maximum consecutive cycles per grant, 0 = unlimited (0..255)
//   IDW       derived width of ids / pointer
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   synchronous active-high reset, highest priority
//   req        in   request levels, one bit per requester
//   done       in   release pulses; only the owner's bit is honoured
//   gnt        out  registered one-hot-or-zero grant vector
//   gnt_valid  out  |gnt
//   gnt_id     out  index of current owner, 0 when idle
//   preempt    out  one-cycle pulse after a forced release
//
// Build option:
//   RR_HOLD_ARBITER_FORMAL_EN  compiles in embedded assertions and a cover.
//   The port list and behaviour do not change.
// -----------------------------------------------------------------------------
module rr_hold_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int MAX_HOLD = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDW-1:0]     gnt_id,
    output logic               preempt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);
    localparam logic [7:0]     HOLD_LAST = 8'((MAX_HOLD == 0) ? 255 : MAX_HOLD - 1);

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [7:0]           hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]       gnt_id_q, gnt_id_d;
    logic                 preempt_q, preempt_d;

    // Release conditions for the current owner
    logic                 owner_done;
    logic                 owner_req;
    logic                 limit_hit;
    logic                 release_now;
    logic                 forced_release;
    logic [IDW-1:0]       ptr_after;

    // Arbitration result
    logic [IDW-1:0]       scan_start;
    logic                 win_found;
    logic [IDW-1:0]       win_idx;
    logic [NUM_REQ-1:0]   win_onehot;

    assign owner_done  = done[gnt_id_q];
    assign owner_req   = req[gnt_id_q];
    assign limit_hit   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    assign release_now = (state_q == BUSY) && (owner_done || !owner_req || limit_hit);
    // A coinciding done/drop counts as a normal release, so only the pure
    // hold-limit case is reported as a preemption.
    assign forced_release = release_now && owner_req && !owner_done;

    // Pointer increment is mod NUM_REQ, not mod 2^IDW, so it can never
    // land on an unused code when NUM_REQ is not a power of two.
    assign ptr_after  = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;

    // While busy the scan only matters on a release, and then it must start
    // just past the releasing owner.
    assign scan_start = (state_q == BUSY) ? ptr_after : ptr_q;

    // Circular first-set scan starting at scan_start
    always_comb begin
        logic [IDW:0]   pos;
        logic [IDW-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, scan_start} + (IDW+1)'(k);
            if (pos >= (IDW+1)'(NUM_REQ)) begin
                pos = pos - (IDW+1)'(NUM_REQ);
            end
            idx = pos[IDW-1:0];
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == IDW'(gi));
        end
    endgenerate

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        preempt_d  = 1'b0;

        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (win_found) begin
                    gnt_d    = win_onehot;
                    gnt_id_d = win_idx;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (release_now) begin
                    ptr_d      = ptr_after;
                    preempt_d  = forced_release;
                    hold_cnt_d = '0;
                    if (win_found) begin
                        gnt_d    = win_onehot;
                        gnt_id_d = win_idx;
                    end else begin
                        gnt_d    = '0;
                        gnt_id_d = '0;
                        state_d  = IDLE;
                    end
                end else if (hold_cnt_q != 8'hFF) begin
                    // Saturation only matters for the unlimited case
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            preempt_q  <= preempt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = gnt_id_q;
    assign preempt   = preempt_q;

`ifdef RR_HOLD_ARBITER_FORMAL_EN
    // History needed by the temporal checks
    logic               init_state_q = 1'b1;
    logic               past_valid_q;
    logic [NUM_REQ-1:0] req_prev_q;
    logic [NUM_REQ-1:0] gnt_prev_q;
    logic               preempt_prev_q;
    logic [NUM_REQ-1:0] forced_seen_q;

    always_ff @(posedge clk) begin
        init_state_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            past_valid_q   <= 1'b0;
            req_prev_q     <= '0;
            gnt_prev_q     <= '0;
            preempt_prev_q <= 1'b0;
            forced_seen_q  <= '0;
        end else begin
            past_valid_q   <= 1'b1;
            req_prev_q     <= req;
            gnt_prev_q     <= gnt_q;
            preempt_prev_q <= preempt_q;
            if (forced_release) begin
                forced_seen_q <= forced_seen_q | gnt_q;
            end
        end
    end

    always @(posedge clk) begin
        if (!(init_state_q || reset)) begin
            assert ($onehot0(gnt_q));
            assert (ptr_q <= LAST_ID);
            assert (gnt_valid == (|gnt_q));
            if (MAX_HOLD != 0 && state_q == BUSY) begin
                assert (hold_cnt_q < 8'(MAX_HOLD));
            end
            if (past_valid_q) begin
                assert ((gnt_q & ~gnt_prev_q & ~req_prev_q) == '0);
                assert (!(preempt_q && preempt_prev_q));
            end
            cover (forced_seen_q == {NUM_REQ{1'b1}});
        end
    end
`endif

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Testbench for rr_hold_arbiter (NUM_REQ=3, MAX_HOLD=4).
// Directed test-plan sequences followed by randomized traffic. Every cycle the
// DUT outputs and pointer are compared against a behavioural model that
// tracks owner / tenure / pointer as plain integers.
module tb_rr_hold_arbiter;

    localparam int N  = 3;
    localparam int MH = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         preempt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_step   = 0;

    // Behavioural model: owner index (-1 = none), tenure = number of cycles
    // the current grant has been visible, pointer, preempt flag.
    int m_own = -1;
    int m_ten = 0;
    int m_ptr = 0;
    int m_pre = 0;

    rr_hold_arbiter #(
        .NUM_REQ  (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (step %0d)", tag, got, exp, n_step);
        end
    endtask

    // First requester at or after 'start' going round the ring, -1 if none
    function automatic int pick(input int start, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (start + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic rst, input logic [N-1:0] r, input logic [N-1:0] d);
        if (rst) begin
            m_own = -1; m_ten = 0; m_ptr = 0; m_pre = 0;
        end else if (m_own < 0) begin
            m_pre = 0;
            m_own = pick(m_ptr, r);
            m_ten = (m_own >= 0) ? 1 : 0;
        end else begin
            bit normal, timeout;
            normal  = d[m_own] || !r[m_own];
            timeout = (MH != 0) && (m_ten >= MH);
            if (normal || timeout) begin
                m_pre = normal ? 0 : 1;
                m_ptr = (m_own + 1) % N;
                m_own = pick(m_ptr, r);
                m_ten = (m_own >= 0) ? 1 : 0;
            end else begin
                m_pre = 0;
                m_ten++;
            end
        end
    endtask

    task automatic step(input logic rst, input logic [N-1:0] r, input logic [N-1:0] d);
        int exp_gnt;
        reset = rst;
        req   = r;
        done  = d;
        @(posedge clk);
        model_edge(rst, r, d);
        #1;
        n_step++;
        exp_gnt = (m_own >= 0) ? (1 << m_own) : 0;
        chk("gnt", int'(gnt), exp_gnt);
        chk("gnt_valid", int'(gnt_valid), (m_own >= 0) ? 1 : 0);
        chk("gnt_id", int'(gnt_id), (m_own >= 0) ? m_own : 0);
        chk("preempt", int'(preempt), m_pre);
        chk("ptr", int'(dut.ptr_q), m_ptr);
        $display("step %0d rst=%0b req=%b done=%b -> gnt=%b id=%0d pre=%0b ptr=%0d",
                 n_step, rst, r, d, gnt, gnt_id, preempt, dut.ptr_q);
    endtask

    initial begin
        int pcnt;
        logic [N-1:0] rq;
        logic [N-1:0] dn;

        reset = 1'b1;
        req   = '0;
        done  = '0;

        // Reset state
        step(1'b1, 3'b000, 3'b000);
        step(1'b1, 3'b000, 3'b000);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_id", int'(gnt_id), 0);

        // Single requester, done releases, pointer moves past it
        step(1'b0, 3'b010, 3'b000);
        chk("tp1_gnt", int'(gnt), 2);
        chk("tp1_id", int'(gnt_id), 1);
        step(1'b0, 3'b010, 3'b000);
        step(1'b0, 3'b000, 3'b010);
        chk("tp1_rel", int'(gnt), 0);
        chk("tp1_ptr", int'(dut.ptr_q), 2);

        // Wrap: ptr=2, req=101 -> 2 wins, then 0 after done
        step(1'b0, 3'b101, 3'b000);
        chk("wrap_gnt", int'(gnt), 4);
        step(1'b0, 3'b101, 3'b100);
        chk("wrap_gnt2", int'(gnt), 1);
        chk("wrap_ptr", int'(dut.ptr_q), 0);

        // Reset while gnt=100, then re-grant one cycle after release of reset
        step(1'b0, 3'b100, 3'b001);
        chk("rst2_pre", int'(gnt), 4);
        step(1'b1, 3'b100, 3'b000);
        chk("rst2_gnt", int'(gnt), 0);
        step(1'b0, 3'b100, 3'b000);
        chk("rst2_regnt", int'(gnt), 4);
        step(1'b0, 3'b000, 3'b000);

        // All request, done on second cycle of each grant: no preemption
        pcnt = 0;
        for (int i = 0; i < 12; i++) begin
            dn = (m_own >= 0 && m_ten == 2) ? 3'(1 << m_own) : 3'b000;
            step(1'b0, 3'b111, dn);
            pcnt += int'(preempt);
        end
        chk("rot_preempts", pcnt, 0);
        step(1'b0, 3'b000, 3'b000);

        // Single continuous requester: forced release every 4 cycles
        pcnt = 0;
        for (int i = 0; i < 13; i++) begin
            step(1'b0, 3'b001, 3'b000);
            pcnt += int'(preempt);
            chk("hold_gnt", int'(gnt), 1);
        end
        chk("hold_preempts", pcnt, 3);
        step(1'b0, 3'b000, 3'b000);

        // All requesting with no done: 4-cycle tenures rotating
        pcnt = 0;
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 3'b111, 3'b000);
            pcnt += int'(preempt);
        end
        chk("rot4_preempts", pcnt, 4);

        // Randomized traffic with sticky requests and occasional reset
        rq = 3'b000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 3'($urandom);
            dn = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b000;
            step(($urandom_range(0, 63) == 0), rq, dn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
